hardware_software_sender: RTL and testbench

//  Hardware-to-CPU message path: queues DATA_W-bit event words from game logic
//  and hands them to the NIOS software one at a time over a 2-bit handshake
//  (to_sw_sig / to_hw_sig) plus a data PIO word. Hardware-initiated; it is the

---
 rtl/hs_comm_pkg.sv | 29 ++
 rtl/hs_msg_fifo.sv | 63 ++++++
 rtl/hardware_software_sender.sv | 146 ++++++++++++++
 tb/tb_hardware_software_sender.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_comm_pkg.sv
// Shared types and handshake codes for the hardware-to-software message sender.
package hs_comm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_RELEASE = 2'd2
  } sender_state_e;

  localparam logic [1:0] SW_IDLE      = 2'd0;
  localparam logic [1:0] SW_MSG_AVAIL = 2'd1;
  localparam logic [1:0] SW_RELEASED  = 2'd3;

  localparam logic [1:0] HW_IDLE      = 2'd0;
  localparam logic [1:0] HW_READ_DONE = 2'd2;

  // Handshake code presented to software for a given sender state.
  function automatic logic [1:0] sw_code(input sender_state_e s);
    logic [1:0] code;
    code = SW_IDLE;
    case (s)
      ST_SEND:    code = SW_MSG_AVAIL;
      ST_RELEASE: code = SW_RELEASED;
      default:    code = SW_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/hs_msg_fifo.sv
// Synchronous message FIFO; a push into a full FIFO succeeds only when paired
// with a pop in the same cycle.
module hs_msg_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic [DATA_W-1:0]        head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/hardware_software_sender.sv
// Hands queued event words to the CPU one at a time over the sig/data PIO
// handshake, abandoning a message if software stalls too long.
module hardware_software_sender
  import hs_comm_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              msg_valid,
  input  logic [DATA_W-1:0] msg_data,
  output logic              msg_ready,
  input  logic [1:0]        to_hw_sig,
  output logic [1:0]        to_sw_sig,
  output logic [DATA_W-1:0] to_sw_data,
  input  logic              err_clr,
  output logic              busy,
  output logic              overflow,
  output logic              timeout_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  sender_state_e       state_q;
  logic [TW-1:0]       timer_q;
  logic [1:0]          hw_meta_q;
  logic [1:0]          hw_sync_q;
  logic [1:0]          to_sw_sig_q;
  logic [DATA_W-1:0]   to_sw_data_q;
  logic                overflow_q;
  logic                timeout_err_q;

  logic [DATA_W-1:0]       fifo_head;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;

  logic start_c;
  logic release_c;
  logic done_c;
  logic expire_c;
  logic pop_c;
  logic push_c;
  logic timer_hit_c;

  hs_msg_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_ni  (reset),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .data_i  (msg_data),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign timer_hit_c = (timer_q == TW'(TIMEOUT_CYC - 1));

  // Transition decisions; the handshake wins over a coincident timeout.
  always_comb begin
    start_c   = 1'b0;
    release_c = 1'b0;
    done_c    = 1'b0;
    expire_c  = 1'b0;
    case (state_q)
      ST_IDLE: start_c = !fifo_empty && (hw_sync_q == HW_IDLE);
      ST_SEND: begin
        release_c = (hw_sync_q == HW_READ_DONE);
        expire_c  = !release_c && timer_hit_c;
      end
      ST_RELEASE: begin
        done_c   = (hw_sync_q == HW_IDLE);
        expire_c = !done_c && timer_hit_c;
      end
      default: ;
    endcase
    pop_c = (state_q == ST_SEND) && (release_c || expire_c);
  end

  assign msg_ready = !fifo_full || pop_c;
  assign push_c    = msg_valid && msg_ready;
  assign busy      = (state_q != ST_IDLE) || (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      hw_meta_q     <= HW_IDLE;
      hw_sync_q     <= HW_IDLE;
      to_sw_sig_q   <= SW_IDLE;
      to_sw_data_q  <= '0;
      overflow_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      hw_meta_q   <= to_hw_sig;
      hw_sync_q   <= hw_meta_q;
      to_sw_sig_q <= sw_code(state_q);
      case (state_q)
        ST_IDLE: begin
          timer_q <= '0;
          if (start_c) begin
            state_q      <= ST_SEND;
            to_sw_data_q <= fifo_head;
          end
        end
        ST_SEND: begin
          if (release_c) begin
            state_q <= ST_RELEASE;
            timer_q <= '0;
          end else if (expire_c) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_RELEASE: begin
          if (done_c || expire_c) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          timer_q <= '0;
        end
      endcase
      overflow_q    <= !err_clr && (overflow_q || (msg_valid && !msg_ready));
      timeout_err_q <= !err_clr && (timeout_err_q || expire_c);
    end
  end

  assign to_sw_sig   = to_sw_sig_q;
  assign to_sw_data  = to_sw_data_q;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_hardware_software_sender.sv
// Directed bench for hardware_software_sender with a short timeout.
module tb_hardware_software_sender;

  logic        clk = 1'b0;
  logic        reset;
  logic        msg_valid;
  logic [31:0] msg_data;
  logic        msg_ready;
  logic [1:0]  to_hw_sig;
  logic [1:0]  to_sw_sig;
  logic [31:0] to_sw_data;
  logic        err_clr;
  logic        busy;
  logic        overflow;
  logic        timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hardware_software_sender #(
    .DATA_W      (32),
    .DEPTH       (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .msg_valid   (msg_valid),
    .msg_data    (msg_data),
    .msg_ready   (msg_ready),
    .to_hw_sig   (to_hw_sig),
    .to_sw_sig   (to_sw_sig),
    .to_sw_data  (to_sw_data),
    .err_clr     (err_clr),
    .busy        (busy),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input logic [1:0] code, input int max_cyc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (to_sw_sig == code) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Software side of one full transfer, checking the presented word.
  task automatic deliver(input string tag, input logic [31:0] exp);
    logic ok;
    wait_sig(2'd1, 40, ok);
    chk({tag, "_avail"}, 32'(ok), 32'd1);
    chk({tag, "_data"}, to_sw_data, exp);
    to_hw_sig = 2'd2;
    wait_sig(2'd3, 20, ok);
    chk({tag, "_released"}, 32'(ok), 32'd1);
    to_hw_sig = 2'd0;
    wait_sig(2'd0, 20, ok);
    chk({tag, "_idle"}, 32'(ok), 32'd1);
  endtask

  task automatic push_burst(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3, input int n);
    logic [31:0] words [4];
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
    for (int i = 0; i < n; i++) begin
      msg_valid = 1'b1;
      msg_data  = words[i];
      tick();
    end
    msg_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic ok;
    logic seen;
    int   n;
    reset     = 1'b0;
    msg_valid = 1'b0;
    msg_data  = '0;
    to_hw_sig = 2'd0;
    err_clr   = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    chk("rst_sig", 32'(to_sw_sig), 32'd0);
    chk("rst_data", to_sw_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    chk("rst_ready", 32'(msg_ready), 32'd1);

    // 1: single message, exact latency
    msg_valid = 1'b1;
    msg_data  = 32'hCAFE0001;
    tick();
    msg_valid = 1'b0;
    chk("t1_sig_n", 32'(to_sw_sig), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_sig_n1", 32'(to_sw_sig), 32'd0);
    tick();
    chk("t1_sig_n2", 32'(to_sw_sig), 32'd1);
    deliver("t1", 32'hCAFE0001);
    chk("t1_busy_end", 32'(busy), 32'd0);

    // 2: fill, overflow, in-order drain, clear
    push_burst(32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 4);
    chk("t2_full_ready", 32'(msg_ready), 32'd0);
    chk("t2_ovf_before", 32'(overflow), 32'd0);
    msg_valid = 1'b1;
    msg_data  = 32'hA0000005;
    tick();
    msg_valid = 1'b0;
    chk("t2_ovf_set", 32'(overflow), 32'd1);
    deliver("t2_w1", 32'hA0000001);
    deliver("t2_w2", 32'hA0000002);
    deliver("t2_w3", 32'hA0000003);
    deliver("t2_w4", 32'hA0000004);
    tick();
    chk("t2_busy_end", 32'(busy), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t2_ovf_clr", 32'(overflow), 32'd0);

    // 3: push into a full FIFO on the pop cycle
    push_burst(32'hB0000001, 32'hB0000002, 32'hB0000003, 32'hB0000004, 4);
    chk("t3_full_ready", 32'(msg_ready), 32'd0);
    chk("t3_sig", 32'(to_sw_sig), 32'd1);
    chk("t3_data", to_sw_data, 32'hB0000001);
    to_hw_sig = 2'd2;
    tick();
    tick();
    chk("t3_ready_on_pop", 32'(msg_ready), 32'd1);
    msg_valid = 1'b1;
    msg_data  = 32'hB0000005;
    tick();
    msg_valid = 1'b0;
    chk("t3_no_ovf", 32'(overflow), 32'd0);
    wait_sig(2'd3, 20, ok);
    chk("t3_released", 32'(ok), 32'd1);
    to_hw_sig = 2'd0;
    wait_sig(2'd0, 20, ok);
    chk("t3_idle", 32'(ok), 32'd1);
    deliver("t3_w2", 32'hB0000002);
    deliver("t3_w3", 32'hB0000003);
    deliver("t3_w4", 32'hB0000004);
    deliver("t3_w5", 32'hB0000005);
    tick();
    chk("t3_busy_end", 32'(busy), 32'd0);

    // 4: software never answers the first word
    push_burst(32'hC0000001, 32'hC0000002, 32'h0, 32'h0, 2);
    wait_sig(2'd1, 20, ok);
    chk("t4_avail", 32'(ok), 32'd1);
    chk("t4_data1", to_sw_data, 32'hC0000001);
    n = 0;
    while (to_sw_sig == 2'd1 && n < 40) begin
      n++;
      tick();
    end
    chk("t4_avail_cycles", 32'(n), 32'd16);
    chk("t4_sig_drop", 32'(to_sw_sig), 32'd0);
    chk("t4_tmo_set", 32'(timeout_err), 32'd1);
    deliver("t4_w2", 32'hC0000002);
    tick();
    chk("t4_busy_end", 32'(busy), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_tmo_clr", 32'(timeout_err), 32'd0);

    // 5: reset while releasing with two words still queued
    push_burst(32'hD0000001, 32'hD0000002, 32'hD0000003, 32'h0, 3);
    wait_sig(2'd1, 20, ok);
    chk("t5_avail", 32'(ok), 32'd1);
    to_hw_sig = 2'd2;
    wait_sig(2'd3, 20, ok);
    chk("t5_released", 32'(ok), 32'd1);
    chk("t5_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    chk("t5_sig", 32'(to_sw_sig), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ready", 32'(msg_ready), 32'd1);
    chk("t5_data", to_sw_data, 32'd0);
    reset     = 1'b1;
    to_hw_sig = 2'd0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (to_sw_sig != 2'd0) seen = 1'b1;
    end
    chk("t5_nothing_sent", 32'(seen), 32'd0);

    // 6: software stuck at READ_DONE before the push; other codes ignored
    to_hw_sig = 2'd2;
    repeat (3) tick();
    msg_valid = 1'b1;
    msg_data  = 32'hE0000001;
    tick();
    msg_valid = 1'b0;
    repeat (5) tick();
    chk("t6_hold_sig", 32'(to_sw_sig), 32'd0);
    chk("t6_hold_busy", 32'(busy), 32'd1);
    to_hw_sig = 2'd0;
    wait_sig(2'd1, 20, ok);
    chk("t6_avail", 32'(ok), 32'd1);
    to_hw_sig = 2'd3;
    repeat (4) tick();
    chk("t6_ignore3", 32'(to_sw_sig), 32'd1);
    to_hw_sig = 2'd0;
    deliver("t6", 32'hE0000001);
    tick();
    chk("t6_busy_end", 32'(busy), 32'd0);
    chk("t6_tmo", 32'(timeout_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
